// File: rtl/ap_ctrl_hs_sequencer.sv
// Upstream ap_ctrl_hs driver: issues NUM_TRANS starts, matches dones to start
// timestamps through a small FIFO, and reports latency/interval stats plus finish.
module ap_ctrl_hs_sequencer #(
    parameter int NUM_TRANS      = 10,
    parameter int MAX_INFLIGHT   = 4,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             run,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             finish,
    output logic             busy,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] done_cnt,
    output logic [CNT_W-1:0] last_latency,
    output logic [CNT_W-1:0] min_latency,
    output logic [CNT_W-1:0] max_latency,
    output logic [CNT_W-1:0] last_interval,
    output logic             timeout_err,
    output logic             protocol_err,
    output logic [2:0]       dbg_state
);

    localparam int AW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int OW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CNT_W-1:0] NUM_C    = CNT_W'(NUM_TRANS);
    localparam logic [OW-1:0]    DEPTH_C  = OW'(MAX_INFLIGHT);
    localparam logic [AW-1:0]    LAST_PTR = AW'(MAX_INFLIGHT - 1);
    localparam logic [31:0]      TMO_C    = 32'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_DRAIN  = 3'd2,
        S_FINISH = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_clear;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_fifo [MAX_INFLIGHT];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [OW-1:0]    r_occ;
    logic [31:0]      r_wdog;
    logic [CNT_W-1:0] r_prev_accept;
    logic [CNT_W-1:0] r_issued_cnt;
    logic [CNT_W-1:0] r_done_cnt;
    logic [CNT_W-1:0] r_last_latency;
    logic [CNT_W-1:0] r_min_latency;
    logic [CNT_W-1:0] r_max_latency;
    logic [CNT_W-1:0] r_last_interval;
    logic             r_timeout_err;
    logic             r_protocol_err;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    logic             w_busy;
    logic             w_fifo_empty;
    logic             w_fifo_full;
    logic             w_start;
    logic             w_accept;
    logic             w_done;
    logic             w_bypass;
    logic             w_pop;
    logic             w_push;
    logic             w_proto;
    logic             w_done_ok;
    logic [CNT_W-1:0] w_lat;
    logic [31:0]      w_wdog_inc;
    logic             w_timeout;
    logic [CNT_W-1:0] w_issued_next;
    logic [CNT_W-1:0] w_done_next;

    // Handshake: a start is accepted on any cycle where ap_start && ap_ready;
    // ap_start comes from registers only and never depends on ap_ready.
    assign w_busy        = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign w_fifo_empty  = (r_occ == '0);
    assign w_fifo_full   = (r_occ == DEPTH_C);
    assign w_start       = (r_state == S_ISSUE) && (r_issued_cnt < NUM_C) && !w_fifo_full;
    assign w_accept      = w_start && ap_ready;
    assign w_done        = w_busy && ap_done;
    assign w_bypass      = w_done && w_accept && w_fifo_empty;
    assign w_pop         = w_done && !w_fifo_empty;
    assign w_push        = w_accept && !w_bypass;
    assign w_proto       = w_done && w_fifo_empty && !w_accept;
    assign w_done_ok     = w_pop || w_bypass;
    assign w_lat         = w_bypass ? '0 : (r_cycle_cnt - r_fifo[r_rd_ptr]);
    assign w_wdog_inc    = r_wdog + 32'd1;
    // A spurious done does not rescue a stalled run, so both errors can coincide.
    assign w_timeout     = w_busy && !w_accept && !w_done_ok && (w_wdog_inc >= TMO_C);
    assign w_issued_next = r_issued_cnt + {{(CNT_W-1){1'b0}}, w_accept};
    assign w_done_next   = r_done_cnt + {{(CNT_W-1){1'b0}}, w_done_ok};

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        case (r_state)
            S_IDLE, S_FINISH, S_ERROR: begin
                if (run) begin
                    w_clear      = 1'b1;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_proto || w_timeout) begin
                    w_state_next = S_ERROR;
                end else if (w_accept && (w_issued_next == NUM_C)) begin
                    w_state_next = (w_done_next == NUM_C) ? S_FINISH : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_proto || w_timeout) begin
                    w_state_next = S_ERROR;
                end else if (w_done_next == NUM_C) begin
                    w_state_next = S_FINISH;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state         <= S_IDLE;
            r_cycle_cnt     <= '0;
            r_rd_ptr        <= '0;
            r_wr_ptr        <= '0;
            r_occ           <= '0;
            r_wdog          <= '0;
            r_prev_accept   <= '0;
            r_issued_cnt    <= '0;
            r_done_cnt      <= '0;
            r_last_latency  <= '0;
            r_min_latency   <= '1;
            r_max_latency   <= '0;
            r_last_interval <= '0;
            r_timeout_err   <= 1'b0;
            r_protocol_err  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
            if (w_clear) begin
                r_rd_ptr        <= '0;
                r_wr_ptr        <= '0;
                r_occ           <= '0;
                r_wdog          <= '0;
                r_prev_accept   <= '0;
                r_issued_cnt    <= '0;
                r_done_cnt      <= '0;
                r_last_latency  <= '0;
                r_min_latency   <= '1;
                r_max_latency   <= '0;
                r_last_interval <= '0;
                r_timeout_err   <= 1'b0;
                r_protocol_err  <= 1'b0;
            end else if (w_busy) begin
                if (w_push) begin
                    r_fifo[r_wr_ptr] <= r_cycle_cnt;
                    r_wr_ptr         <= ptr_inc(r_wr_ptr);
                end
                if (w_pop) begin
                    r_rd_ptr <= ptr_inc(r_rd_ptr);
                end
                if (w_push && !w_pop) begin
                    r_occ <= r_occ + 1'b1;
                end else if (w_pop && !w_push) begin
                    r_occ <= r_occ - 1'b1;
                end
                if (w_accept) begin
                    r_issued_cnt  <= w_issued_next;
                    r_prev_accept <= r_cycle_cnt;
                    if (r_issued_cnt != '0) begin
                        r_last_interval <= r_cycle_cnt - r_prev_accept;
                    end
                end
                if (w_done_ok) begin
                    r_done_cnt     <= w_done_next;
                    r_last_latency <= w_lat;
                    if (w_lat < r_min_latency) r_min_latency <= w_lat;
                    if (w_lat > r_max_latency) r_max_latency <= w_lat;
                end
                if (w_proto)   r_protocol_err <= 1'b1;
                if (w_timeout) r_timeout_err  <= 1'b1;
                r_wdog <= (w_accept || ap_done) ? '0 : w_wdog_inc;
            end
        end
    end

    assign ap_start      = w_start;
    assign finish        = (r_state == S_FINISH) || (r_state == S_ERROR);
    assign busy          = w_busy;
    assign issued_cnt    = r_issued_cnt;
    assign done_cnt      = r_done_cnt;
    assign last_latency  = r_last_latency;
    assign min_latency   = r_min_latency;
    assign max_latency   = r_max_latency;
    assign last_interval = r_last_interval;
    assign timeout_err   = r_timeout_err;
    assign protocol_err  = r_protocol_err;
    assign dbg_state     = r_state;

endmodule

// File: doc/ap_ctrl_hs_sequencer.md
Name: ap_ctrl_hs_sequencer

Overview:
- Upstream driver for the block-level ap_ctrl_hs interface of the HLS top (myproject) in cosim and on-board self-test.
- Issues NUM_TRANS transactions on ap_start and tracks ap_ready/ap_done.
- Measures per-transaction latency and start interval.
- Raises finish, which the dataflow/module-status monitor consumes to end sampling and dump CSV.

Parameters:
- NUM_TRANS, 10, transactions issued per run (>=1).
- MAX_INFLIGHT, 4, depth of start-timestamp FIFO; power of 2, >=1.
- CNT_W, 32, width of cycle counter, latency and interval outputs.
- TIMEOUT_CYCLES, 100000, watchdog limit with no accepted start and no done.

Ports:
- ap_clk  in  1  clock; all state updates on rising edge.
- ap_rst_n  in  1  reset, synchronous, active-low.
- run  in  1  start a run; sampled in IDLE, FINISH or ERROR.
- ap_start  out  1  to DUT ap_start.
- ap_ready  in  1  from DUT; input accepted when ap_start&&ap_ready.
- ap_done  in  1  from DUT; one transaction completes per cycle high.
- finish  out  1  run complete (normal or error); to monitor.
- busy  out  1  high in ISSUE or DRAIN.
- issued_cnt  out  CNT_W  accepted starts this run.
- done_cnt  out  CNT_W  dones this run.
- last_latency  out  CNT_W  latency of most recent done, cycles.
- min_latency  out  CNT_W  minimum latency this run.
- max_latency  out  CNT_W  maximum latency this run.
- last_interval  out  CNT_W  cycles between the last two accepted starts.
- timeout_err  out  1  watchdog expired.
- protocol_err  out  1  ap_done with no outstanding transaction.

Behaviour:
- Reset: on ap_clk edge with ap_rst_n=0 → state IDLE.
  - All outputs 0, except min_latency = all-ones.
  - FIFO empty; cycle_cnt = 0; watchdog = 0.
  - Reset mid-run aborts immediately; ap_start is low the cycle after the reset edge.
- cycle_cnt increments every cycle after reset and wraps modulo 2^CNT_W. Latency/interval subtraction is also modulo 2^CNT_W.
- accept = ap_start && ap_ready.
- State IDLE:
  - ap_start=0.
  - run=1 → clear counters, stats and errors; FIFO empty; → ISSUE.
- State ISSUE:
  - ap_start = (issued_cnt < NUM_TRANS) && !fifo_full.
  - ap_start is decoded from registers only; there is no combinational path from ap_ready.
  - ap_start never drops without an accept, since the FIFO only fills on accept.
  - On accept:
    - push cycle_cnt; issued_cnt++.
    - last_interval = cycle_cnt - prev_accept_time, updated from the second accept onward.
  - Accept making issued_cnt == NUM_TRANS → DRAIN.
- State DRAIN:
  - ap_start=0.
  - done_cnt == NUM_TRANS → FINISH.
- Done handling (ISSUE and DRAIN):
  - On ap_done: pop FIFO head; last_latency = cycle_cnt - head; update min/max; done_cnt++.
  - Same-cycle accept and done with FIFO empty: bypass; latency 0; FIFO unchanged.
  - Same-cycle accept and done with FIFO non-empty: pop head and push new entry in the same cycle; occupancy unchanged.
    - If the FIFO was full, no accept is possible because ap_start=0. A pop in that cycle re-enables ap_start the next cycle.
  - ap_done with FIFO empty and no accept: protocol_err=1 → ERROR.
- Watchdog:
  - Counts in ISSUE/DRAIN; cleared on any accept or ap_done.
  - Reaching TIMEOUT_CYCLES → timeout_err=1 → ERROR.
  - timeout_err and protocol_err in the same cycle: both flags set.
- State FINISH / ERROR:
  - finish=1 (level, held); ap_start=0; busy=0.
  - Error flags and stats are held.
  - run=1 → clear and → ISSUE; finish drops the next cycle.
- ap_done in IDLE/FINISH/ERROR is ignored; no counter or flag changes.
- NUM_TRANS reached by done_cnt in the same cycle as the last accept (bypass): ISSUE → FINISH directly.

Test Plan:
- Ideal DUT: ap_ready tied 1, ap_done 3 cycles after accept, NUM_TRANS=10 → issued_cnt=10, done_cnt=10, min=max=last_latency=3, last_interval=1, finish rises 1 cycle after 10th done; stays high.
- Back-pressure: MAX_INFLIGHT=4, DUT latency 20, ap_ready=1 → ap_start drops after 4 accepts; each done re-enables exactly one accept; max_latency=20; FIFO never exceeds 4.
- Combinational DUT: ap_done = accept same cycle → all latencies 0, no protocol_err, finish after 10 cycles of ap_start.
- Spurious done: pulse ap_done with FIFO empty in ISSUE → protocol_err=1, finish=1, ap_start=0 next cycle.
- Hang: ap_ready held 0, TIMEOUT_CYCLES=50 → timeout_err=1 after 50 cycles in ISSUE, finish=1, issued_cnt=0.
- Reset mid-run: drop ap_rst_n for 1 cycle after 5 accepts → all outputs at reset values, min_latency=all-ones; then run=1 → clean 10-transaction run.
